// File: rtl/shift_count_sequencer.sv
// Shift-count sequencer: loads an alignment shift amount (clipped to MAX_COUNT) and
// issues exactly that many single-cycle shift strobes, with hold, abort and optional auto-reload.
module shift_count_sequencer #(
   parameter int WIDTH       = 5,
   parameter int MAX_COUNT   = 27,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] count,
   input  logic             Hold,
   input  logic             Abort,
   output logic [WIDTH-1:0] Q,
   output logic             shift_enable,
   output logic             shift_active,
   output logic             busy,
   output logic             done,
   output logic             clipped
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] reload_reg, reload_next;
   logic             clipped_reg, clipped_next;

   logic             over_max;
   logic [WIDTH-1:0] load_value;
   logic             reload_go;

   assign over_max   = (count > MAX_Q);
   assign load_value = over_max ? MAX_Q : count;
   // A stored value of zero would only produce an endless stream of done pulses, so it stops the loop.
   assign reload_go  = AUTO_RELOAD && (reload_reg != '0);

   always_comb begin
      state_next   = state_reg;
      q_next       = q_reg;
      reload_next  = reload_reg;
      clipped_next = clipped_reg;

      if (Abort) begin
         state_next   = ST_IDLE;
         q_next       = '0;
         clipped_next = 1'b0;
      end else if (Load) begin
         q_next       = load_value;
         reload_next  = load_value;
         clipped_next = over_max;
         state_next   = (load_value != '0) ? ST_COUNT : ST_DONE;
      end else begin
         case (state_reg)
            ST_COUNT: begin
               if (!Hold) begin
                  // Q never wraps: the final strobe lands on zero and hands over to DONE.
                  if (q_reg <= ONE_Q) begin
                     q_next     = '0;
                     state_next = ST_DONE;
                  end else begin
                     q_next = q_reg - ONE_Q;
                  end
               end
            end
            ST_DONE: begin
               if (reload_go) begin
                  q_next     = reload_reg;
                  state_next = ST_COUNT;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg   <= ST_IDLE;
         q_reg       <= '0;
         reload_reg  <= '0;
         clipped_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         q_reg       <= q_next;
         reload_reg  <= reload_next;
         clipped_reg <= clipped_next;
      end
   end

   assign Q            = q_reg;
   assign shift_enable = (q_reg == '0);
   assign busy         = (state_reg == ST_COUNT);
   assign done         = (state_reg == ST_DONE);
   assign shift_active = busy & ~Hold;
   assign clipped      = clipped_reg;

endmodule

// File: tb/tb_shift_count_sequencer.sv
// Bench for shift_count_sequencer: one instance without and one with auto-reload,
// driven together and compared every cycle against an abstract run/remaining model.
module tb_shift_count_sequencer;

   localparam int W    = 5;
   localparam int MAXC = 27;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic         Reset = 1'b0, Load = 1'b0, Hold = 1'b0, Abort = 1'b0;
   logic [W-1:0] count = '0;

   logic [W-1:0] q_o [2];
   logic         se_o[2], sa_o[2], b_o[2], d_o[2], c_o[2];

   shift_count_sequencer #(.WIDTH(W), .MAX_COUNT(MAXC), .AUTO_RELOAD(1'b0)) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .count(count), .Hold(Hold), .Abort(Abort),
      .Q(q_o[0]), .shift_enable(se_o[0]), .shift_active(sa_o[0]), .busy(b_o[0]),
      .done(d_o[0]), .clipped(c_o[0]));

   shift_count_sequencer #(.WIDTH(W), .MAX_COUNT(MAXC), .AUTO_RELOAD(1'b1)) dut_ar (
      .Clk(Clk), .Reset(Reset), .Load(Load), .count(count), .Hold(Hold), .Abort(Abort),
      .Q(q_o[1]), .shift_enable(se_o[1]), .shift_active(sa_o[1]), .busy(b_o[1]),
      .done(d_o[1]), .clipped(c_o[1]));

   int n_checks = 0;
   int n_pass   = 0;

   // Reference: a run is "shifts still owed", plus a one-cycle done flag.
   int m_q[2], m_stored[2];
   bit m_run[2], m_done[2], m_clip[2];
   bit model_valid = 1'b0;

   int strobes[2], dones[2];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic void model_step(input int i, input bit r, input bit a, input bit l,
                                      input int c, input bit h);
      int v;
      if (r) begin
         m_q[i] = 0; m_stored[i] = 0; m_run[i] = 0; m_done[i] = 0; m_clip[i] = 0;
      end else if (a) begin
         m_q[i] = 0; m_run[i] = 0; m_done[i] = 0; m_clip[i] = 0;
      end else if (l) begin
         v = (c > MAXC) ? MAXC : c;
         m_q[i] = v; m_stored[i] = v; m_clip[i] = (c > MAXC);
         m_run[i] = (v != 0); m_done[i] = (v == 0);
      end else if (m_run[i]) begin
         if (!h) begin
            m_q[i] = m_q[i] - 1;
            if (m_q[i] == 0) begin m_run[i] = 0; m_done[i] = 1; end
         end
      end else if (m_done[i]) begin
         m_done[i] = 0;
         if (i == 1 && m_stored[i] != 0) begin m_q[i] = m_stored[i]; m_run[i] = 1; end
      end
   endfunction

   task automatic tick(input bit r, input bit a, input bit l, input int c, input bit h);
      Reset = r; Abort = a; Load = l; count = W'(c); Hold = h;
      #1;
      if (model_valid) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("inst%0d shift_active", i), int'(sa_o[i]), int'(m_run[i] && !h));
            strobes[i] += int'(sa_o[i]);
         end
      end
      @(posedge Clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         model_step(i, r, a, l, c, h);
         chk($sformatf("inst%0d Q", i),            int'(q_o[i]),  m_q[i]);
         chk($sformatf("inst%0d shift_enable", i), int'(se_o[i]), int'(m_q[i] == 0));
         chk($sformatf("inst%0d busy", i),         int'(b_o[i]),  int'(m_run[i]));
         chk($sformatf("inst%0d done", i),         int'(d_o[i]),  int'(m_done[i]));
         chk($sformatf("inst%0d clipped", i),      int'(c_o[i]),  int'(m_clip[i]));
         dones[i] += int'(d_o[i]);
      end
      model_valid = 1'b1;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin strobes[i] = 0; dones[i] = 0; end
   endtask

   typedef struct {
      bit r, a, l; int c; bit h;
      int eq; bit eb, ed, ec;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit a, input bit l, input int c, input bit h,
                               input int eq, input bit eb, input bit ed, input bit ec);
      vec_t v;
      v.r = r; v.a = a; v.l = l; v.c = c; v.h = h;
      v.eq = eq; v.eb = eb; v.ed = ed; v.ec = ec;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      int done_at;

      // Expected registered outputs of the non-reload instance after each vector's edge.
      vecs.push_back(mk(1,0,0, 0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,1, 5,0,  5,1,0,0));
      vecs.push_back(mk(0,0,0, 0,0,  4,1,0,0));
      vecs.push_back(mk(0,0,0, 0,0,  3,1,0,0));
      vecs.push_back(mk(0,0,0, 0,0,  2,1,0,0));
      vecs.push_back(mk(0,0,0, 0,0,  1,1,0,0));
      vecs.push_back(mk(0,0,0, 0,0,  0,0,1,0));
      vecs.push_back(mk(0,0,0, 0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,1, 0,0,  0,0,1,0));
      vecs.push_back(mk(0,0,0, 0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,1,31,0, 27,1,0,1));
      vecs.push_back(mk(0,0,1, 3,0,  3,1,0,0));
      vecs.push_back(mk(0,1,0, 0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,1, 2,0,  2,1,0,0));
      vecs.push_back(mk(0,0,0, 0,1,  2,1,0,0));
      vecs.push_back(mk(0,0,0, 0,1,  2,1,0,0));
      vecs.push_back(mk(0,0,0, 0,0,  1,1,0,0));
      vecs.push_back(mk(0,0,0, 0,0,  0,0,1,0));
      vecs.push_back(mk(0,0,1,31,0, 27,1,0,1));
      vecs.push_back(mk(0,1,1, 9,0,  0,0,0,0));
      vecs.push_back(mk(0,0,1,30,1, 27,1,0,1));
      vecs.push_back(mk(1,0,1, 5,0,  0,0,0,0));

      foreach (vecs[n]) begin
         tick(vecs[n].r, vecs[n].a, vecs[n].l, vecs[n].c, vecs[n].h);
         chk($sformatf("vec%0d Q", n),       int'(q_o[0]), vecs[n].eq);
         chk($sformatf("vec%0d busy", n),    int'(b_o[0]), int'(vecs[n].eb));
         chk($sformatf("vec%0d done", n),    int'(d_o[0]), int'(vecs[n].ed));
         chk($sformatf("vec%0d clipped", n), int'(c_o[0]), int'(vecs[n].ec));
      end

      // Clipped load: 27 strobes, one done, then the next load clears clipped.
      tick(1,0,0,0,0); clear_counts();
      tick(0,0,1,31,0);
      for (int n = 0; n < 35; n++) tick(0,0,0,0,0);
      chk("clip strobes", strobes[0], 27);
      chk("clip dones", dones[0], 1);
      chk("clip held", int'(c_o[0]), 1);
      tick(0,0,1,3,0);
      chk("clip cleared", int'(c_o[0]), 0);

      // Hold for 3 cycles after the 2nd strobe: Q frozen at 4, done delayed by 3.
      tick(1,0,0,0,0); clear_counts();
      tick(0,0,1,6,0);
      tick(0,0,0,0,0);
      tick(0,0,0,0,0);
      for (int n = 0; n < 3; n++) begin
         tick(0,0,0,0,1);
         chk("hold Q frozen", int'(q_o[0]), 4);
      end
      done_at = -1;
      for (int n = 7; n <= 30; n++) begin
         tick(0,0,0,0,0);
         if (d_o[0] && done_at < 0) done_at = n;
      end
      chk("hold strobes", strobes[0], 6);
      chk("hold done cycle", done_at, 10);

      // Abort after 3 strobes: no done pulse.
      tick(1,0,0,0,0); clear_counts();
      tick(0,0,1,8,0);
      tick(0,0,0,0,0);
      tick(0,0,0,0,0);
      tick(0,1,0,0,0);
      chk("abort Q", int'(q_o[0]), 0);
      chk("abort busy", int'(b_o[0]), 0);
      for (int n = 0; n < 4; n++) tick(0,0,0,0,0);
      chk("abort strobes", strobes[0], 3);
      chk("abort dones", dones[0], 0);

      // Reload mid-run: 2 + 4 strobes, single done.
      tick(1,0,0,0,0); clear_counts();
      tick(0,0,1,10,0);
      tick(0,0,0,0,0);
      tick(0,0,1,4,0);
      for (int n = 0; n < 10; n++) tick(0,0,0,0,0);
      chk("reload strobes", strobes[0], 6);
      chk("reload dones", dones[0], 1);

      // Reset mid-run.
      tick(0,0,1,8,0);
      tick(0,0,0,0,0);
      tick(1,0,0,0,0);
      chk("midreset Q", int'(q_o[0]), 0);
      chk("midreset busy", int'(b_o[0]), 0);
      chk("midreset done", int'(d_o[0]), 0);

      // Auto-reload: period of 3 strobes + done until abort.
      clear_counts();
      tick(0,0,1,3,0);
      for (int n = 0; n < 16; n++) tick(0,0,0,0,0);
      chk("autoreload strobes", strobes[1], 12);
      chk("autoreload dones", dones[1], 4);
      tick(0,1,0,0,0);
      clear_counts();
      for (int n = 0; n < 5; n++) begin
         tick(0,0,0,0,0);
         chk("post-abort Q", int'(q_o[1]), 0);
      end
      chk("post-abort strobes", strobes[1], 0);
      chk("post-abort dones", dones[1], 0);

      // Random stimulus against the model.
      for (int n = 0; n < 1500; n++) begin
         bit r, a, l, h;
         int c;
         r = ($urandom_range(0, 99) == 0);
         a = ($urandom_range(0, 29) == 0);
         l = ($urandom_range(0, 11) == 0);
         h = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
         tick(r, a, l, c, h);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
